if_fetch_unit: RTL and testbench

Parametrised instruction-fetch stage that replaces the single-cycle PC/fetch block. It decouples the PC from a variable-latency instruction memory using a valid/ready request channel, in-order responses and a bounded number of outstanding requests. It buffers fetched instructions in a fetch queue and presents them to ID through a valid/ready handshake. Redirects (JALR, branch, JAL) flush the queue and use an epoch bit to discard stale in-flight responses.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/if_fetch_unit_if.sv | 43 ++++
 rtl/if_fetch_unit_fetch_fifo.sv | 74 +++++++
 rtl/if_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared core types. The fetch stage adds its queue entry, its in-flight
// request tag and a NOP encoding for consumers that need a bubble.
package riscv_pkg;

  localparam int FETCH_XLEN = 32;

  // addi x0, x0, 0
  localparam logic [FETCH_XLEN-1:0] FETCH_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic                  epoch;
  } fetch_tag_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus: imem request/response channel plus the ID-facing handshake.
// master = fetch unit side, slave = memory / decode side.
interface if_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pc_plus_4;
  logic [XLEN-1:0] id_instr;

  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output id_valid,
    input  id_ready,
    output id_pc,
    output id_pc_plus_4,
    output id_instr
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  id_valid,
    output id_ready,
    input  id_pc,
    input  id_pc_plus_4,
    input  id_instr
  );

endinterface

// File: rtl/if_fetch_unit_fetch_fifo.sv
// Synchronous FIFO with flush. The head entry is read combinationally so a
// value pushed in one cycle is visible at the head in the next.
module fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [31:0]
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output T                       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;
  T              slots [DEPTH];

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign count   = count_reg;
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    T slot_reg;

    always_ff @(posedge clk) begin
      if (do_push && (wr_ptr_reg == AW'(gi))) begin
        slot_reg <= push_data;
      end
    end

    assign slots[gi] = slot_reg;
  end

  assign head = slots[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (do_pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Decoupled instruction fetch: credit-limited imem requests, in-order responses
// tagged with a redirect epoch, and a fetch queue presenting instructions to ID.
module if_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000,
  parameter int              FQ_DEPTH        = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      jalr_taken,
  input  logic [XLEN-1:0]           jalr_target,
  input  logic                      branch_taken,
  input  logic [XLEN-1:0]           branch_target,
  input  logic                      jal_taken,
  input  logic [XLEN-1:0]           jal_target,
  if_fetch_unit_if.master           bus,
  output logic [$clog2(FQ_DEPTH):0] fq_count
);

  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

  logic [XLEN-1:0] fetch_pc_reg;
  logic [XLEN-1:0] fetch_pc_next;
  logic            epoch_reg;
  logic            epoch_next;

  logic            redirect;
  logic [XLEN-1:0] redirect_target;

  logic [OW-1:0]   outstanding;
  logic [31:0]     credit_sum;
  logic            req_fire;

  logic            tag_full;
  logic            tag_empty;
  fetch_tag_t      tag_push_data;
  fetch_tag_t      tag_head;

  logic            fq_full;
  logic            fq_empty;
  logic            fq_push;
  logic            fq_pop;
  fetch_entry_t    fq_push_data;
  fetch_entry_t    fq_head;

  always_comb begin
    redirect        = jalr_taken | branch_taken | jal_taken;
    redirect_target = jal_target;
    if (jalr_taken) begin
      redirect_target = jalr_target;
    end else if (branch_taken) begin
      redirect_target = branch_target;
    end
  end

  // Credit rule: every accepted request owns a fetch-queue slot, so a
  // response can always be pushed without backpressure.
  assign credit_sum         = 32'(outstanding) + 32'(fq_count);
  assign bus.imem_req_valid = !rst && !tag_full && (credit_sum < 32'(FQ_DEPTH));
  assign bus.imem_req_addr  = fetch_pc_reg;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  // A request accepted during a redirect carries the old pc and old epoch,
  // so its response is discarded on arrival.
  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    epoch_next    = epoch_reg;
    if (redirect) begin
      fetch_pc_next = {redirect_target[XLEN-1:2], 2'b00};
      epoch_next    = !epoch_reg;
    end else if (req_fire) begin
      fetch_pc_next = fetch_pc_reg + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg <= {RESET_PC[XLEN-1:2], 2'b00};
      epoch_reg    <= 1'b0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      epoch_reg    <= epoch_next;
    end
  end

  assign tag_push_data = '{pc: fetch_pc_reg, epoch: epoch_reg};

  fetch_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .T     (fetch_tag_t)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_data (tag_push_data),
    .pop       (bus.imem_rsp_valid),
    .flush     (1'b0),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (outstanding)
  );

  assign fq_push      = bus.imem_rsp_valid && (tag_head.epoch == epoch_reg) && !redirect;
  assign fq_push_data = '{pc: tag_head.pc, instr: bus.imem_rsp_data};
  assign fq_pop       = bus.id_valid && bus.id_ready;

  fetch_fifo #(
    .DEPTH (FQ_DEPTH),
    .T     (fetch_entry_t)
  ) u_fetch_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (fq_push),
    .push_data (fq_push_data),
    .pop       (fq_pop),
    .flush     (redirect),
    .head      (fq_head),
    .full      (fq_full),
    .empty     (fq_empty),
    .count     (fq_count)
  );

  assign bus.id_valid     = !fq_empty && !redirect;
  assign bus.id_pc        = fq_empty ? '0 : fq_head.pc;
  assign bus.id_pc_plus_4 = fq_empty ? '0 : fq_head.pc + XLEN'(4);
  assign bus.id_instr     = fq_empty ? '0 : fq_head.instr;

  a_rsp_has_request : assert property (
    @(posedge clk) disable iff (rst) bus.imem_rsp_valid |-> !tag_empty
  );

  a_queue_has_room : assert property (
    @(posedge clk) disable iff (rst) fq_push |-> (!fq_full || fq_pop)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: queue-level reference model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_if_fetch_unit;

  localparam int          XLEN     = 32;
  localparam int          FQ_DEPTH = 4;
  localparam int          MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jalr_taken = 1'b0;
  logic        branch_taken = 1'b0;
  logic        jal_taken = 1'b0;
  logic [31:0] jalr_target = '0;
  logic [31:0] branch_target = '0;
  logic [31:0] jal_target = '0;
  logic [2:0]  fq_count;

  if_fetch_unit_if #(.XLEN(XLEN)) bus ();

  if_fetch_unit #(
    .XLEN            (XLEN),
    .RESET_PC        (RESET_PC),
    .FQ_DEPTH        (FQ_DEPTH),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .jalr_taken    (jalr_taken),
    .jalr_target   (jalr_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jal_taken     (jal_taken),
    .jal_target    (jal_target),
    .bus           (bus),
    .fq_count      (fq_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int mem_lat = 1;

  typedef struct { int due; logic [31:0] addr; } mem_rsp_t;
  typedef struct { logic [31:0] pc; int gen; } inflight_t;
  typedef struct { int cyc; logic [31:0] addr; } req_rec_t;
  typedef struct { int cyc; logic [31:0] pc; logic [31:0] pc4; logic [31:0] instr; } id_rec_t;

  mem_rsp_t    rsp_q[$];
  int          last_due = 0;
  inflight_t   out_q[$];
  logic [31:0] fq_model[$];
  logic [31:0] exp_fetch_pc = RESET_PC;
  logic [31:0] stream_pc = RESET_PC;
  int          gen = 0;
  req_rec_t    req_log[$];
  id_rec_t     id_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_n, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory: answers accepted requests in order, mem_lat cycles after accept.
  always begin
    @(posedge clk);
    #1;
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc_n) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(rsp_q[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
  end

  // Reference model: the fetch queue is the list of pcs whose responses came
  // back after the most recent redirect; ID must see pcs sequentially from it.
  always @(negedge clk) begin : model
    logic        redir;
    logic [31:0] tgt;
    logic        exp_req_valid;
    logic        fire;
    inflight_t   t;
    int          due;
    redir = jalr_taken | branch_taken | jal_taken;
    tgt   = jalr_taken ? jalr_target : (branch_taken ? branch_target : jal_target);
    if (rst) begin
      check("rst_req_valid", bus.imem_req_valid, 1'b0);
      out_q.delete();
      fq_model.delete();
      rsp_q.delete();
      last_due     = cyc_n;
      exp_fetch_pc = RESET_PC;
      stream_pc    = RESET_PC;
    end else begin
      exp_req_valid = (out_q.size() < MAX_OUT) && (out_q.size() + fq_model.size() < FQ_DEPTH);
      check("req_valid", bus.imem_req_valid, exp_req_valid);
      if (exp_req_valid) check("req_addr", bus.imem_req_addr, exp_fetch_pc);
      check("fq_count", fq_count, fq_model.size());
      check("id_valid", bus.id_valid, (fq_model.size() > 0) && !redir);
      if (fq_model.size() > 0) begin
        check("id_pc", bus.id_pc, fq_model[0]);
        check("id_pc_plus_4", bus.id_pc_plus_4, fq_model[0] + 32'd4);
        check("id_instr", bus.id_instr, mem_word(fq_model[0]));
      end
      fire = bus.imem_req_valid && bus.imem_req_ready;
      if (bus.id_valid && bus.id_ready) begin
        check("id_stream_pc", bus.id_pc, stream_pc);
        id_log.push_back('{cyc_n, bus.id_pc, bus.id_pc_plus_4, bus.id_instr});
        stream_pc = stream_pc + 32'd4;
        if (fq_model.size() > 0) void'(fq_model.pop_front());
      end
      if (bus.imem_rsp_valid) begin
        if (out_q.size() == 0) begin
          check("rsp_has_request", 32'd0, 32'd1);
        end else begin
          t = out_q.pop_front();
          if (t.gen == gen && !redir) fq_model.push_back(t.pc);
        end
        if (rsp_q.size() > 0) void'(rsp_q.pop_front());
      end
      if (fire) begin
        out_q.push_back('{exp_fetch_pc, gen});
        req_log.push_back('{cyc_n, bus.imem_req_addr});
        due = cyc_n + mem_lat;
        if (due <= last_due) due = last_due + 1;
        rsp_q.push_back('{due, bus.imem_req_addr});
        last_due     = due;
        exp_fetch_pc = exp_fetch_pc + 32'd4;
      end
      if (redir) begin
        fq_model.delete();
        gen++;
        exp_fetch_pc = {tgt[31:2], 2'b00};
        stream_pc    = {tgt[31:2], 2'b00};
      end
    end
    cyc_n++;
  end

  function automatic logic [31:0] req_addr_after(input int cyc, input int skip);
    int n = 0;
    foreach (req_log[i]) begin
      if (req_log[i].cyc > cyc) begin
        if (n == skip) return req_log[i].addr;
        n++;
      end
    end
    return 32'hDEAD_BEEF;
  endfunction

  function automatic id_rec_t id_at(input int i);
    id_rec_t none = '{-1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    if (i < id_log.size()) return id_log[i];
    return none;
  endfunction

  task automatic wait_inflight(input int need_out, input int need_fq, input string name);
    int n = 0;
    while (!(out_q.size() >= need_out && fq_model.size() >= need_fq) && n < 40) begin
      tick();
      n++;
    end
    check(name, 32'(n < 40), 32'd1);
  endtask

  task automatic redirect_pulse(input logic [2:0] which, input logic [31:0] t_jalr,
                                input logic [31:0] t_br, input logic [31:0] t_jal,
                                output int rcyc);
    jalr_taken    = which[2];
    branch_taken  = which[1];
    jal_taken     = which[0];
    jalr_target   = t_jalr;
    branch_target = t_br;
    jal_target    = t_jal;
    rcyc = cyc_n;
    req_log.delete();
    id_log.delete();
    tick();
    jalr_taken   = 1'b0;
    branch_taken = 1'b0;
    jal_taken    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rel;
    int rcyc;
    int bad;
    bus.imem_req_ready = 1'b1;
    bus.id_ready       = 1'b1;
    repeat (3) tick();

    check("reset_req_valid", bus.imem_req_valid, 1'b0);
    check("reset_id_valid", bus.id_valid, 1'b0);
    check("reset_fq_count", fq_count, 3'd0);
    check("reset_id_pc", bus.id_pc, 32'h0);
    check("reset_id_pc_plus_4", bus.id_pc_plus_4, 32'h0);
    check("reset_id_instr", bus.id_instr, 32'h0);

    // Zero-wait streaming after reset release.
    rst = 1'b0;
    rel = cyc_n;
    req_log.delete();
    id_log.delete();
    repeat (12) tick();
    for (int i = 0; i < 4; i++) begin
      check("p1_req_addr", req_addr_after(rel - 1, i), 32'(4 * i));
      if (i < req_log.size()) check("p1_req_cycle", req_log[i].cyc, rel + i);
    end
    check("p1_first_id_cycle", id_at(0).cyc, rel + 2);
    check("p1_first_id_pc", id_at(0).pc, 32'h0);
    check("p1_first_id_instr", id_at(0).instr, 32'h1357_9BDF);
    check("p1_second_id_pc", id_at(1).pc, 32'h4);

    // Decode stall: queue saturates, requests throttle, nothing in flight.
    bus.id_ready = 1'b0;
    repeat (10) tick();
    check("p2_fq_count_full", fq_count, 3'd4);
    check("p2_req_valid_low", bus.imem_req_valid, 1'b0);
    check("p2_outstanding_zero", out_q.size(), 32'd0);
    bus.id_ready = 1'b1;
    repeat (12) tick();
    bad = 0;
    foreach (id_log[i]) if (id_log[i].pc != 32'(4 * i)) bad++;
    check("p2_in_order_count", 32'(id_log.size() >= 20), 32'd1);
    check("p2_in_order_bad", bad, 32'd0);

    // Slow memory, branch while two requests are in flight.
    mem_lat = 3;
    repeat (8) tick();
    wait_inflight(2, 0, "p3_two_inflight");
    redirect_pulse(3'b010, 32'h0, 32'h100, 32'h0, rcyc);
    repeat (15) tick();
    check("p3_first_pc", id_at(0).pc, 32'h100);
    check("p3_first_instr", id_at(0).instr, 32'h1357_9ADF);
    check("p3_second_pc", id_at(1).pc, 32'h104);

    // Zero-wait redirect latency.
    mem_lat = 1;
    repeat (6) tick();
    redirect_pulse(3'b001, 32'h0, 32'h0, 32'h80, rcyc);
    repeat (8) tick();
    check("p3b_latency_cycle", id_at(0).cyc, rcyc + 3);
    check("p3b_latency_pc", id_at(0).pc, 32'h80);

    // Simultaneous redirects: JALR wins.
    redirect_pulse(3'b111, 32'h200, 32'h300, 32'h400, rcyc);
    repeat (8) tick();
    check("p4_priority_req", req_addr_after(rcyc, 0), 32'h200);
    check("p4_priority_id", id_at(0).pc, 32'h200);

    // Unaligned target near the top of memory, then address wrap.
    redirect_pulse(3'b001, 32'h0, 32'h0, 32'hFFFF_FFFE, rcyc);
    repeat (8) tick();
    check("p5_req_top", req_addr_after(rcyc, 0), 32'hFFFF_FFFC);
    check("p5_req_wrap", req_addr_after(rcyc, 1), 32'h0);
    check("p5_id_top_pc", id_at(0).pc, 32'hFFFF_FFFC);
    check("p5_id_top_pc4", id_at(0).pc4, 32'h0);
    check("p5_id_wrap_pc", id_at(1).pc, 32'h0);

    // Reset in the middle of traffic.
    mem_lat = 3;
    bus.id_ready = 1'b0;
    wait_inflight(1, 2, "p6_busy_before_reset");
    rst = 1'b1;
    tick();
    check("p6_id_valid_after_rst", bus.id_valid, 1'b0);
    check("p6_fq_count_after_rst", fq_count, 3'd0);
    rst = 1'b0;
    rel = cyc_n;
    req_log.delete();
    bus.id_ready = 1'b1;
    repeat (8) tick();
    check("p6_first_req_addr", req_addr_after(rel - 1, 0), RESET_PC);
    if (req_log.size() > 0) check("p6_first_req_cycle", req_log[0].cyc, rel);
    else check("p6_first_req_present", 32'd0, 32'd1);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
